// File: rtl/block_data_memory.sv
// Block-organised backing store for the data cache: whole-block fills and write-backs
// with a fixed LATENCY-cycle busywait handshake. Optional statistics: DMEM_STATS_EN.
module block_data_memory #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       read_count,
  output logic [15:0]       write_count
`endif
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                op_write_q, op_write_d;
  logic [DATA_W-1:0]   readdata_q;
  logic                req;
  logic                do_op;

  logic [DATA_W-1:0]   mem [0:(2**ADDR_W)-1];

  assign req   = read | write;
  assign do_op = (state_q == ACCESS) && (cnt_q == '0);

  // State and latched request registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_write_d = op_write_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = ACCESS;
          cnt_d      = CNT_LOAD;
          addr_d     = address;
          wdata_d    = writedata;
          op_write_d = write;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The stall is combinational in IDLE so the cache stalls in its request cycle
  always_comb begin
    busywait = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE:    busywait = req;
        ACCESS:  busywait = 1'b1;
        default: busywait = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_op && op_write_q) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    readdata_q <= '0;
    else if (do_op && !op_write_q) readdata_q <= mem[addr_q];
  end

  assign readdata = readdata_q;

`ifdef DMEM_STATS_EN
  logic [15:0] read_count_q, write_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else if (do_op) begin
      if (op_write_q && write_count_q != 16'hFFFF) write_count_q <= write_count_q + 16'd1;
      if (!op_write_q && read_count_q != 16'hFFFF) read_count_q  <= read_count_q + 16'd1;
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory (LATENCY=5): fills, write-backs, latency,
// latched-request behaviour, reset abort and read/write collision.
module tb_block_data_memory;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;
`ifdef DMEM_STATS_EN
  logic [15:0] read_count;
  logic [15:0] write_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  block_data_memory #(.ADDR_W(6), .DATA_W(32), .LATENCY(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait)
`ifdef DMEM_STATS_EN
    ,
    .read_count  (read_count),
    .write_count (write_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full handshake; optionally scrambles address/writedata after acceptance.
  task automatic access(input logic wr, input logic rd, input logic [5:0] a,
                        input logic [31:0] d, input bit scramble,
                        output logic [31:0] rdata);
    int edges;
    @(negedge clock);
    write = wr; read = rd; address = a; writedata = d;
    #1;
    check("bw_req", {31'b0, busywait}, 32'd1);
    edges = 0;
    do begin
      @(posedge clock); #1;
      edges++;
      if (scramble && edges == 1) begin
        address   = ~a;
        writedata = ~d;
      end
    end while (busywait && edges < 40);
    check("latency_edges", edges, 32'd6);
    rdata = readdata;
    read = 1'b0; write = 1'b0;
    @(posedge clock); #1;
    check("bw_idle", {31'b0, busywait}, 32'd0);
    $display("[TB] op wr=%0b rd=%0b addr=%h wdata=%h readdata=%h edges=%0d",
             wr, rd, a, d, rdata, edges);
  endtask

  logic [31:0] rd_v;

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    #12;
    check("rst_busywait", {31'b0, busywait}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Write then read back
    access(1'b1, 1'b0, 6'h05, 32'hDEADBEEF, 1'b0, rd_v);
    access(1'b0, 1'b1, 6'h05, 32'h0, 1'b0, rd_v);
    check("t1_read05", rd_v, 32'hDEADBEEF);

    // Boundary and assorted addresses
    access(1'b1, 1'b0, 6'h00, 32'hC0FFEE00, 1'b0, rd_v);
    access(1'b1, 1'b0, 6'h15, 32'h15151515, 1'b0, rd_v);
    access(1'b1, 1'b0, 6'h2A, 32'h2A2A2A2A, 1'b0, rd_v);
    access(1'b0, 1'b1, 6'h15, 32'h0, 1'b0, rd_v);
    check("read15", rd_v, 32'h15151515);
    access(1'b0, 1'b1, 6'h2A, 32'h0, 1'b0, rd_v);
    check("read2A", rd_v, 32'h2A2A2A2A);

    // Inputs changed during ACCESS must not affect the write (scramble targets 6'h00)
    access(1'b1, 1'b0, 6'h3F, 32'hCAFEF00D, 1'b1, rd_v);
    access(1'b0, 1'b1, 6'h3F, 32'h0, 1'b0, rd_v);
    check("t3_read3F", rd_v, 32'hCAFEF00D);
    access(1'b0, 1'b1, 6'h00, 32'h0, 1'b0, rd_v);
    check("t3_read00", rd_v, 32'hC0FFEE00);

    // Simultaneous read and write behaves as a write; readdata keeps prior value
    access(1'b0, 1'b1, 6'h05, 32'h0, 1'b0, rd_v);
    access(1'b1, 1'b1, 6'h02, 32'hA5A5A5A5, 1'b0, rd_v);
    check("t5_rd_held", rd_v, 32'hDEADBEEF);
    access(1'b0, 1'b1, 6'h02, 32'h0, 1'b0, rd_v);
    check("t5_read02", rd_v, 32'hA5A5A5A5);

    // Reset during the second ACCESS cycle aborts the write
    access(1'b1, 1'b0, 6'h01, 32'h11111111, 1'b0, rd_v);
    access(1'b0, 1'b1, 6'h05, 32'h0, 1'b0, rd_v);
    @(negedge clock);
    write = 1'b1; address = 6'h01; writedata = 32'h12345678;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("t4_busy_before", {31'b0, busywait}, 32'd1);
    reset = 1'b0;
    #1;
    check("t4_bw_rst", {31'b0, busywait}, 32'd0);
    check("t4_rd_rst", readdata, 32'd0);
    $display("[TB] reset asserted mid-ACCESS for write addr=01 data=12345678");
    write = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(posedge clock);
    access(1'b0, 1'b1, 6'h01, 32'h0, 1'b0, rd_v);
    check("t4_mem1_kept", rd_v, 32'h11111111);

`ifdef DMEM_STATS_EN
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("st_rst_rc", {16'b0, read_count}, 32'd0);
    check("st_rst_wc", {16'b0, write_count}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    access(1'b0, 1'b1, 6'h05, 32'h0, 1'b0, rd_v);
    access(1'b1, 1'b0, 6'h10, 32'h01020304, 1'b0, rd_v);
    access(1'b0, 1'b1, 6'h10, 32'h0, 1'b0, rd_v);
    access(1'b1, 1'b0, 6'h11, 32'h05060708, 1'b0, rd_v);
    access(1'b0, 1'b1, 6'h11, 32'h0, 1'b0, rd_v);
    check("st_rc", {16'b0, read_count}, 32'd3);
    check("st_wc", {16'b0, write_count}, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
